spi_mem_slave: RTL



---
 rtl/spi_mem_pkg.sv | 20 ++
 rtl/spi_pin_sync.sv | 57 +++++
 rtl/spi_mem_slave.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_mem_pkg.sv
// Shared SPI memory-protocol definitions: opcodes and responder state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package spi_mem_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_WRITE     = 8'h02;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_READ   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_IGNORE = 3'd5,
        ST_DUMMY  = 3'd6
    } state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes spi_clk, spi_cs_n and MOSI into clk and produces edge pulses.
// Latency: SYNC_STAGES clk cycles from pin to synced level / edge pulse.
// Backpressure: none; edge pulses are single-cycle and never stall.
module spi_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    // Shift each pin through its chain; MOSI uses the same depth so it stays aligned with SCLK.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_prev_d = sclk_sync_q[SYNC_STAGES-1];
        cs_prev_d   = cs_sync_q[SYNC_STAGES-1];
    end

    // Idle levels at reset: SCLK low (mode 0), CS deasserted, so no false edges after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
        end
    end

    assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
    assign cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_prev_q;
    assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_prev_q;
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_mem_slave.sv
// SPI mode-0 READ/WRITE responder bridging to a req/ack byte memory; SPI_MEM_SLAVE_FAST_READ_EN adds 0x0B.
// Latency: mem_req one clk after the synced SCLK edge that completes address/byte; MISO one clk after synced fall.
// Backpressure: none on SPI; slow mem_ack yields 0x00 read bytes or dropped write bytes plus sticky err_flag.
module spi_mem_slave
    import spi_mem_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        spi_cs_n,
    input  logic [3:0]  spi_io_in,
    output logic [3:0]  spi_io_out,
    output logic [3:0]  spi_io_oe,
    output logic        mem_req,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic        err_flag,
    input  logic        err_clr
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
    logic unused_io;

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [22:0]   sh_in_q, sh_in_d;
    logic [23:0]   addr_q, addr_d;
    logic          rd_q, rd_d;
    logic [7:0]    tx_q, tx_d;
    logic          miso_q, miso_d;
    logic          oe_q, oe_d;
    logic [7:0]    rbuf_q, rbuf_d;
    logic          rbuf_vld_q, rbuf_vld_d;
    logic          pend_q, pend_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          req_q, req_d;
    logic          we_q, we_d;
    logic [23:0]   maddr_q, maddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          err_q, err_d;
    logic          err_set;
    logic [7:0]    ld_byte;
    logic [7:0]    byte_in;
    logic [23:0]   addr_in;
`ifdef SPI_MEM_SLAVE_FAST_READ_EN
    logic          fast_q, fast_d;
`endif

    assign unused_io = ^spi_io_in[3:1];

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .spi_clk   (spi_clk),
        .spi_cs_n  (spi_cs_n),
        .spi_mosi  (spi_io_in[0]),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .mosi_s    (mosi_s)
    );

    // Value of the shift register including the bit arriving on this rising edge.
    assign byte_in = {sh_in_q[6:0], mosi_s};
    assign addr_in = {sh_in_q[22:0], mosi_s};

    // Next-state, memory handshake and MISO shifting; CS rise overrides everything at the end.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_in_d    = sh_in_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        rbuf_d     = rbuf_q;
        rbuf_vld_d = rbuf_vld_q;
        pend_d     = pend_q;
        tmr_d      = tmr_q;
        req_d      = 1'b0;
        we_d       = we_q;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;
        err_set    = 1'b0;
        ld_byte    = 8'h00;
`ifdef SPI_MEM_SLAVE_FAST_READ_EN
        fast_d     = fast_q;
`endif

        // Outstanding request: accept ack, or give up after ACK_TIMEOUT cycles.
        // A timed-out read leaves 0x00 in the buffer so the next byte is well defined.
        if (pend_q) begin
            if (mem_ack) begin
                pend_d = 1'b0;
                if (state_q == ST_READ || state_q == ST_DUMMY) begin
                    rbuf_d     = mem_rdata;
                    rbuf_vld_d = 1'b1;
                end
                if (state_q == ST_READ) oe_d = 1'b1;
            end else if (tmr_q == TW'(ACK_TIMEOUT - 1)) begin
                pend_d  = 1'b0;
                err_set = 1'b1;
                if (state_q == ST_READ || state_q == ST_DUMMY) begin
                    rbuf_d     = 8'h00;
                    rbuf_vld_d = 1'b1;
                end
            end else begin
                tmr_d = tmr_q + TW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_CMD;
                    cnt_d   = 5'd0;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    sh_in_d = {sh_in_q[21:0], mosi_s};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d   = 5'd0;
                        state_d = ST_ADDR;
                        case (byte_in)
                            OP_READ:  rd_d = 1'b1;
                            OP_WRITE: rd_d = 1'b0;
`ifdef SPI_MEM_SLAVE_FAST_READ_EN
                            OP_FAST_READ: begin
                                rd_d   = 1'b1;
                                fast_d = 1'b1;
                            end
`endif
                            default: begin
                                state_d = ST_IGNORE;
                                err_set = 1'b1;
                            end
                        endcase
`ifdef SPI_MEM_SLAVE_FAST_READ_EN
                        if (byte_in != OP_FAST_READ) fast_d = 1'b0;
`endif
                    end
                end
            end
            ST_ADDR: begin
                if (sclk_rise) begin
                    sh_in_d = {sh_in_q[21:0], mosi_s};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd23) begin
                        cnt_d  = 5'd0;
                        addr_d = addr_in;
                        if (!rd_q) begin
                            state_d = ST_WRITE;
                        end else
`ifdef SPI_MEM_SLAVE_FAST_READ_EN
                        if (fast_q) begin
                            state_d = ST_DUMMY;
                        end else
`endif
                        begin
                            state_d = ST_READ;
                            req_d   = 1'b1;
                            we_d    = 1'b0;
                            maddr_d = addr_in;
                            pend_d  = 1'b1;
                            tmr_d   = '0;
                        end
                    end
                end
            end
`ifdef SPI_MEM_SLAVE_FAST_READ_EN
            ST_DUMMY: begin
                if (sclk_rise) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd0) begin
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        maddr_d = addr_q;
                        pend_d  = 1'b1;
                        tmr_d   = '0;
                    end
                    if (cnt_q == 5'd7) begin
                        cnt_d   = 5'd0;
                        state_d = ST_READ;
                    end
                end
            end
`endif
            ST_READ: begin
                if (sclk_fall) begin
                    oe_d  = 1'b1;
                    cnt_d = (cnt_q[2:0] == 3'd7) ? 5'd0 : cnt_q + 5'd1;
                    if (cnt_q[2:0] == 3'd0) begin
                        // Byte boundary: take the fetched byte (or 0x00 if it is late), then prefetch.
                        if (rbuf_vld_q || (pend_q && mem_ack)) begin
                            ld_byte = (pend_q && mem_ack) ? mem_rdata : rbuf_q;
                        end else begin
                            ld_byte = 8'h00;
                            err_set = 1'b1;
                        end
                        rbuf_vld_d = 1'b0;
                        miso_d     = ld_byte[7];
                        tx_d       = {ld_byte[6:0], 1'b0};
                        addr_d     = addr_q + 24'd1;
                        req_d      = 1'b1;
                        we_d       = 1'b0;
                        maddr_d    = addr_q + 24'd1;
                        pend_d     = 1'b1;
                        tmr_d      = '0;
                    end else begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                end
            end
            ST_WRITE: begin
                if (sclk_rise) begin
                    sh_in_d = {sh_in_q[21:0], mosi_s};
                    cnt_d   = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        cnt_d = 5'd0;
                        if (pend_q && !mem_ack) begin
                            err_set = 1'b1;
                        end else begin
                            req_d   = 1'b1;
                            we_d    = 1'b1;
                            maddr_d = addr_q;
                            wdata_d = byte_in;
                            addr_d  = addr_q + 24'd1;
                            pend_d  = 1'b1;
                            tmr_d   = '0;
                        end
                    end
                end
            end
            ST_IGNORE: begin
            end
            default: state_d = ST_IDLE;
        endcase

        // CS deassertion aborts immediately; late acks then find nothing outstanding.
        if (cs_rise) begin
            state_d    = ST_IDLE;
            cnt_d      = 5'd0;
            oe_d       = 1'b0;
            miso_d     = 1'b0;
            pend_d     = 1'b0;
            rbuf_vld_d = 1'b0;
            req_d      = 1'b0;
        end

        err_d = err_clr ? 1'b0 : (err_q | err_set);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 5'd0;
            sh_in_q    <= '0;
            addr_q     <= '0;
            rd_q       <= 1'b0;
            tx_q       <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            rbuf_q     <= '0;
            rbuf_vld_q <= 1'b0;
            pend_q     <= 1'b0;
            tmr_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_in_q    <= sh_in_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            rbuf_q     <= rbuf_d;
            rbuf_vld_q <= rbuf_vld_d;
            pend_q     <= pend_d;
            tmr_q      <= tmr_d;
            req_q      <= req_d;
            we_q       <= we_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
        end
    end

`ifdef SPI_MEM_SLAVE_FAST_READ_EN
    // Fast-read flag for the current transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fast_q <= 1'b0;
        else        fast_q <= fast_d;
    end
`endif

    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = (state_q != ST_IDLE);
    assign err_flag   = err_q;
    assign spi_io_out = {2'b00, miso_q, 1'b0};
    assign spi_io_oe  = {2'b00, oe_q, 1'b0};

endmodule
